// File: rtl/stack_pkg.sv
// Shared definitions for the stack-pointer controller: op codes and FSM states.
package stack_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_PUSH2 = 3'b100;
    localparam logic [2:0] OP_POP2  = 3'b101;
    localparam logic [2:0] OP_CLRF  = 3'b110;
    localparam logic [2:0] OP_NOP2  = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SECOND = 1'b1
    } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Full-descending stack pointer with one/two-word push/pop, occupancy status
// and sticky overflow/underflow/range flags; drives the data-memory address.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]   STACK_TOP = 8'hFF,
    parameter int unsigned         DEPTH     = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] ld_val,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic              busy,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf,
    output logic              rng_err
);

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LOW_LIM = STACK_TOP - DEPTH_W;
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO     = ADDR_W'(2);

    state_t            r_state;
    logic              r_dir_push;
    logic [ADDR_W-1:0] r_sp;
    logic              r_ovf;
    logic              r_unf;
    logic              r_rng_err;

    logic [ADDR_W-1:0] w_count;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_push2_ok;
    logic              w_pop2_ok;
    logic              w_ld_ok;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_count = STACK_TOP - r_sp;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_push_ok  = (w_count < DEPTH_W);
        w_pop_ok   = (w_count != '0);
        w_push2_ok = ((DEPTH_W - w_count) >= TWO);
        w_pop2_ok  = (w_count >= TWO);
        w_ld_ok    = (ld_val >= LOW_LIM) && (ld_val <= STACK_TOP);
        w_do_push  = 1'b0;
        w_do_pop   = 1'b0;
        mem_addr   = r_sp;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        if (r_state == S_SECOND) begin
            // Second beat was validated when the two-word op was accepted.
            w_do_push = r_dir_push;
            w_do_pop  = !r_dir_push;
        end else begin
            case (op)
                OP_PUSH:  w_do_push = w_push_ok;
                OP_POP:   w_do_pop  = w_pop_ok;
                OP_PUSH2: w_do_push = w_push2_ok;
                OP_POP2:  w_do_pop  = w_pop2_ok;
                default:  ;
            endcase
        end

        if (w_do_push) begin
            mem_we = 1'b1;
        end
        if (w_do_pop) begin
            mem_re   = 1'b1;
            mem_addr = r_sp + ONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (rst) begin
            r_state    <= S_IDLE;
            r_dir_push <= 1'b0;
            r_sp       <= STACK_TOP;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_rng_err  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_sp <= r_sp - ONE;
            end else if (w_do_pop) begin
                r_sp <= r_sp + ONE;
            end

            if (r_state == S_SECOND) begin
                r_state <= S_IDLE;
            end else begin
                case (op)
                    OP_PUSH: if (!w_push_ok) r_ovf <= 1'b1;
                    OP_POP:  if (!w_pop_ok)  r_unf <= 1'b1;
                    OP_LOAD: begin
                        if (w_ld_ok) r_sp      <= ld_val;
                        else         r_rng_err <= 1'b1;
                    end
                    OP_PUSH2: begin
                        if (w_push2_ok) begin
                            r_state    <= S_SECOND;
                            r_dir_push <= 1'b1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                    OP_POP2: begin
                        if (w_pop2_ok) begin
                            r_state    <= S_SECOND;
                            r_dir_push <= 1'b0;
                        end else begin
                            r_unf <= 1'b1;
                        end
                    end
                    OP_CLRF: begin
                        r_ovf     <= 1'b0;
                        r_unf     <= 1'b0;
                        r_rng_err <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sp      = r_sp;
    assign busy    = (r_state == S_SECOND);
    assign count   = w_count;
    assign full    = (w_count == DEPTH_W);
    assign empty   = (w_count == '0);
    assign ovf     = r_ovf;
    assign unf     = r_unf;
    assign rng_err = r_rng_err;

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Parametrised successor to the RNBIP-2 stack pointer. Holds a full-descending stack pointer and drives the data-memory address and strobes for stack accesses. Adds two-word push/pop for CALL/RET of a 16-bit PC, explicit full/empty/occupancy status, and sticky overflow/underflow/range error flags. Sits between the control unit (op decode) and the data-memory address mux.

Parameters:
ADDR_W, 8, width of stack pointer and memory address
STACK_TOP, 8'hFF, reset and empty value of SP (first free slot)
DEPTH, 80, maximum entries; full when SP == STACK_TOP - DEPTH (8'hAF at defaults)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
op  in  3  stack operation, sampled only when busy=0
ld_val  in  ADDR_W  new SP value for LOAD (from r0)
sp  out  ADDR_W  current stack pointer (registered)
mem_addr  out  ADDR_W  stack access address this cycle
mem_we  out  1  write strobe (push beat)
mem_re  out  1  read strobe (pop beat)
busy  out  1  high during second beat of a 2-word op
count  out  ADDR_W  occupancy = STACK_TOP - sp
full  out  1  count == DEPTH
empty  out  1  count == 0
ovf  out  1  sticky: push rejected for lack of space
unf  out  1  sticky: pop rejected for lack of data
rng_err  out  1  sticky: LOAD value outside [STACK_TOP-DEPTH, STACK_TOP]

Behaviour:
- Reset (sync, rst=1 at edge): sp=STACK_TOP, state=IDLE, ovf=unf=rng_err=0; hence busy=0, count=0, empty=1, full=0, mem_we=mem_re=0. rst wins over any op, including mid two-word op (second beat dropped).
- Op codes: 000 NOP; 001 PUSH; 010 POP; 011 LOAD; 100 PUSH2; 101 POP2; 110 CLRF (clear sticky flags); 111 NOP.
- Convention: full-descending, SP points to next free slot. Push writes at sp then sp<=sp-1. Pop reads at sp+1 then sp<=sp+1.
- mem_addr/mem_we/mem_re are combinational from state, sp and op; access happens in the op cycle; sp updates at the closing edge. When no access, mem_addr=sp, strobes 0.
- PUSH: if count<DEPTH: mem_we=1, mem_addr=sp, sp-1. Else no strobe, sp unchanged, ovf<=1.
- POP: if count>0: mem_re=1, mem_addr=sp+1, sp+1. Else no strobe, unf<=1.
- LOAD: if STACK_TOP-DEPTH <= ld_val <= STACK_TOP, sp<=ld_val; else sp unchanged, rng_err<=1. No strobes.
- PUSH2/POP2 atomic: checked up front for 2 free/2 used entries. If insufficient: no strobes, no SP change, ovf/unf<=1, stay IDLE. If sufficient: beat 1 in op cycle (as PUSH/POP), move to SECOND; beat 2 next cycle with busy=1 (same direction), return to IDLE. PUSH2 writes high byte first, POP2 reads low byte first.
- FSM: IDLE -> SECOND on accepted PUSH2/POP2; SECOND -> IDLE unconditionally. op ignored while busy=1.
- CLRF clears ovf, unf, rng_err the next edge; an error event never coincides with CLRF (single op per cycle).
- Address arithmetic modulo 2^ADDR_W; range checks use full-width unsigned compares. Parameters require STACK_TOP >= DEPTH.
- full/empty/count derived from registered sp only.

Decomposition:
- Package stack_pkg: op code localparams (OP_NOP..OP_CLRF), FSM state encoding (S_IDLE, S_SECOND).
- Single module, no sub-module: one sequential block (sp, state, flags) plus one combinational block (strobes, mem_addr, accept checks).

Test Plan:
- Reset then PUSH x3 -> mem_we pulses at addr FF, FE, FD; sp=FC, count=3, empty=0.
- From sp=FF, POP -> no mem_re, sp stays FF, unf=1; CLRF -> unf=0 next cycle.
- LOAD ld_val=B0 then PUSH -> write at B0, sp=AF, full=1; further PUSH -> sp AF, ovf=1, no mem_we.
- sp=FF, PUSH2 -> writes FF then FE on consecutive cycles, busy=1 only in 2nd cycle, op=POP during busy ignored; then POP2 -> reads FE then FF, sp=FF.
- sp=B0, PUSH2 -> rejected whole, no writes, sp=B0, ovf=1; LOAD ld_val=10 -> sp unchanged, rng_err=1.
- Assert rst during SECOND of PUSH2 -> no second write, sp=FF, busy=0, flags 0.
